// File: rtl/urp_pcie_dll_rx.sv
// urp_pcie_dll_rx: receive-side PCIe data link layer.
// Checks the LCRC and the sequence number of each incoming frame. In-order good
// TLPs go to the transaction layer through a one-entry output register. Bad,
// duplicate and out-of-order frames are discarded. ACK/NAK DLLPs are generated
// for the transmitter's replay logic.
module urp_pcie_dll_rx #(
  parameter int unsigned ACK_LATENCY  = 16,
  parameter int unsigned ACK_COALESCE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [267:0] rx_tlp_data_i,
  input  logic         rx_tlp_valid_i,
  output logic         rx_tlp_ready_o,
  output logic [223:0] tlp_o,
  output logic         tlp_valid_o,
  input  logic         tlp_ready_i,
  output logic [31:0]  dllp_o,
  output logic         dllp_valid_o,
  input  logic         dllp_ready_i,
  output logic [11:0]  next_rcv_seq_o
);

  localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;
  localparam logic [7:0]  TIMER_MAX = 8'(ACK_LATENCY - 1);
  localparam logic [3:0]  COAL_THR  = 4'(ACK_COALESCE);
  localparam logic [7:0]  TYPE_ACK  = 8'h00;
  localparam logic [7:0]  TYPE_NAK  = 8'h10;

  // LCRC over seq + body, MSB first, no reflection, inverted result.
  function automatic logic [31:0] lcrc_236(input logic [235:0] d);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 235; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return ~c;
  endfunction

  logic [11:0]  nrs_q, nrs_d;
  logic         nak_sched_q, nak_sched_d;
  logic         nak_req_q, nak_req_d;
  logic         ack_pend_q, ack_pend_d;
  logic         dup_seen_q, dup_seen_d;
  logic [3:0]   coal_q, coal_d;
  logic [7:0]   timer_q, timer_d;
  logic [223:0] tlp_q, tlp_d;
  logic         tlp_valid_q, tlp_valid_d;
  logic [31:0]  dllp_q, dllp_d;
  logic         dllp_valid_q, dllp_valid_d;

  logic         accept;
  logic [11:0]  rx_seq;
  logic         crc_ok;
  logic [11:0]  seq_dist;
  logic         in_order;
  logic         dup_frame;
  logic         reject;
  logic         slot_free;
  logic [11:0]  acknak_seq;

  assign rx_tlp_ready_o = !tlp_valid_q || tlp_ready_i;
  assign accept         = rx_tlp_valid_i && rx_tlp_ready_o;
  assign rx_seq         = rx_tlp_data_i[267:256];
  assign crc_ok         = (lcrc_236(rx_tlp_data_i[267:32]) == rx_tlp_data_i[31:0]);
  assign seq_dist       = nrs_q - rx_seq;
  // A distance of 1..2048 behind NRS is an already-received frame; anything else
  // ahead of NRS is a gap and must be NAKed.
  assign in_order       = accept && crc_ok && (seq_dist == 12'd0);
  assign dup_frame      = accept && crc_ok && (seq_dist != 12'd0) && (seq_dist <= 12'd2048);
  assign reject         = accept && !in_order && !dup_frame;
  assign slot_free      = !dllp_valid_q || dllp_ready_i;

  // Next-state: frame classification first, then DLLP issue on the updated values
  // so that a DLLP issued in an accept cycle already covers that frame.
  always_comb begin
    nrs_d        = nrs_q;
    nak_sched_d  = nak_sched_q;
    nak_req_d    = nak_req_q;
    ack_pend_d   = ack_pend_q;
    dup_seen_d   = dup_seen_q;
    coal_d       = coal_q;
    timer_d      = timer_q;
    tlp_d        = tlp_q;
    tlp_valid_d  = tlp_valid_q;
    dllp_d       = dllp_q;
    dllp_valid_d = dllp_valid_q;
    acknak_seq   = 12'd0;

    if (tlp_valid_q && tlp_ready_i) tlp_valid_d = 1'b0;

    if (in_order) begin
      tlp_d       = rx_tlp_data_i[255:32];
      tlp_valid_d = 1'b1;
      nrs_d       = nrs_q + 12'd1;
      nak_sched_d = 1'b0;
      ack_pend_d  = 1'b1;
      if (coal_q != 4'hF) coal_d = coal_q + 4'd1;
    end else if (dup_frame) begin
      ack_pend_d = 1'b1;
      dup_seen_d = 1'b1;
    end else if (reject && !nak_sched_q) begin
      nak_sched_d = 1'b1;
      nak_req_d   = 1'b1;
    end

    acknak_seq = nrs_d - 12'd1;

    if (dllp_valid_q && dllp_ready_i) dllp_valid_d = 1'b0;

    if (slot_free && nak_req_d) begin
      dllp_d       = {TYPE_NAK, 12'h000, acknak_seq};
      dllp_valid_d = 1'b1;
      nak_req_d    = 1'b0;
      ack_pend_d   = 1'b0;
      dup_seen_d   = 1'b0;
      timer_d      = 8'd0;
      coal_d       = 4'd0;
    end else if (slot_free && ack_pend_d &&
                 ((timer_q == TIMER_MAX) || (coal_d >= COAL_THR) || dup_seen_d)) begin
      dllp_d       = {TYPE_ACK, 12'h000, acknak_seq};
      dllp_valid_d = 1'b1;
      ack_pend_d   = 1'b0;
      dup_seen_d   = 1'b0;
      timer_d      = 8'd0;
      coal_d       = 4'd0;
    end else if (ack_pend_q && (timer_q != TIMER_MAX)) begin
      timer_d = timer_q + 8'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      nrs_q        <= 12'd0;
      nak_sched_q  <= 1'b0;
      nak_req_q    <= 1'b0;
      ack_pend_q   <= 1'b0;
      dup_seen_q   <= 1'b0;
      coal_q       <= 4'd0;
      timer_q      <= 8'd0;
      tlp_q        <= '0;
      tlp_valid_q  <= 1'b0;
      dllp_q       <= 32'd0;
      dllp_valid_q <= 1'b0;
    end else begin
      nrs_q        <= nrs_d;
      nak_sched_q  <= nak_sched_d;
      nak_req_q    <= nak_req_d;
      ack_pend_q   <= ack_pend_d;
      dup_seen_q   <= dup_seen_d;
      coal_q       <= coal_d;
      timer_q      <= timer_d;
      tlp_q        <= tlp_d;
      tlp_valid_q  <= tlp_valid_d;
      dllp_q       <= dllp_d;
      dllp_valid_q <= dllp_valid_d;
    end
  end

  assign tlp_o          = tlp_q;
  assign tlp_valid_o    = tlp_valid_q;
  assign dllp_o         = dllp_q;
  assign dllp_valid_o   = dllp_valid_q;
  assign next_rcv_seq_o = nrs_q;

endmodule

// File: tb/tb_urp_pcie_dll_rx.sv
// Bench for urp_pcie_dll_rx: a classification vector table plus directed
// sequences for ACK timing, coalescing, wrap, backpressure and reset.
module tb_urp_pcie_dll_rx;

  logic         clk = 1'b0;
  logic         rst;
  logic [267:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [223:0] tlp;
  logic         tlp_valid;
  logic         tlp_ready;
  logic [31:0]  dllp;
  logic         dllp_valid;
  logic         dllp_ready;
  logic [11:0]  nrs;

  int n_cmp = 0;
  int n_err = 0;

  urp_pcie_dll_rx #(.ACK_LATENCY(16), .ACK_COALESCE(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_tlp_data_i  (rx_data),
    .rx_tlp_valid_i (rx_valid),
    .rx_tlp_ready_o (rx_ready),
    .tlp_o          (tlp),
    .tlp_valid_o    (tlp_valid),
    .tlp_ready_i    (tlp_ready),
    .dllp_o         (dllp),
    .dllp_valid_o   (dllp_valid),
    .dllp_ready_i   (dllp_ready),
    .next_rcv_seq_o (nrs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] seq;
    logic        valid;
    int          flip;
    logic        exp_tlp;
    logic [11:0] exp_nrs;
    logic        exp_dv;
    logic [31:0] exp_dllp;
  } vec_t;

  vec_t vt[15];

  // Reference CRC: XOR the message bit into the top, then shift/reduce.
  function automatic logic [31:0] ref_crc(input logic [255:0] d, input int n);
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    for (int i = n - 1; i >= 0; i--) begin
      r = r ^ ({31'b0, d[i]} << 31);
      if (r[31]) r = (r << 1) ^ 32'h04C1_1DB7;
      else       r = r << 1;
    end
    return ~r;
  endfunction

  function automatic logic [223:0] body_of(input logic [11:0] seq);
    logic [31:0] w;
    w = 32'hC0DE_0000 | {20'h0, seq};
    return {7{w}};
  endfunction

  function automatic logic [267:0] make_frame(input logic [11:0] seq, input int flip);
    logic [267:0] f;
    logic [223:0] b;
    b = body_of(seq);
    f = {seq, b, ref_crc({20'h0, seq, b}, 236)};
    if (flip >= 0) f[flip] = ~f[flip];
    return f;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] seq, input int flip);
    rx_data  = make_frame(seq, flip);
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid   = 1'b0;
    rst        = 1'b1;
    tick();
    tick();
    rst        = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tlp_valid"}, tlp_valid, 0);
    chk({tag, "_dllp_valid"}, dllp_valid, 0);
    chk({tag, "_tlp_o"}, tlp, 0);
    chk({tag, "_dllp_o"}, dllp, 0);
    chk({tag, "_nrs"}, nrs, 0);
    chk({tag, "_rx_ready"}, rx_ready, 1);
  endtask

  initial begin
    int   first_at;
    int   dv_count;
    logic [31:0] first_val;

    rst        = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = '0;
    tlp_ready  = 1'b1;
    dllp_ready = 1'b1;

    // model sanity: CRC-32/BZIP2 check value of "123456789"
    chk("crc_model", ref_crc({184'h0, 72'h31_3233_3435_3637_3839}, 72), 32'hFC89_1918);

    //             seq     v  flip  tlp nrs    dv  dllp
    vt[0]  = '{12'd0,  1, -1,  1, 12'd1, 0, 32'h0};
    vt[1]  = '{12'd0,  1, 100, 0, 12'd1, 1, 32'h1000_0000};
    vt[2]  = '{12'd5,  1, -1,  0, 12'd1, 0, 32'h0};
    vt[3]  = '{12'd1,  1, -1,  1, 12'd2, 0, 32'h0};
    vt[4]  = '{12'd3,  1, 40,  0, 12'd2, 1, 32'h1000_0001};
    vt[5]  = '{12'd2,  1, -1,  1, 12'd3, 0, 32'h0};
    vt[6]  = '{12'd1,  1, -1,  0, 12'd3, 1, 32'h0000_0002};
    vt[7]  = '{12'd3,  1, -1,  1, 12'd4, 0, 32'h0};
    vt[8]  = '{12'd4,  1, -1,  1, 12'd5, 0, 32'h0};
    vt[9]  = '{12'd5,  1, -1,  1, 12'd6, 0, 32'h0};
    vt[10] = '{12'd6,  1, -1,  1, 12'd7, 1, 32'h0000_0006};
    vt[11] = '{12'd7,  1, 0,   0, 12'd7, 1, 32'h1000_0006};
    vt[12] = '{12'd7,  1, 267, 0, 12'd7, 0, 32'h0};
    vt[13] = '{12'd7,  0, -1,  0, 12'd7, 0, 32'h0};
    vt[14] = '{12'd7,  1, -1,  1, 12'd8, 0, 32'h0};

    // reset state
    do_reset();
    chk_idle("reset");

    // classification table, one frame per cycle
    for (int i = 0; i < 15; i++) begin
      rx_data  = make_frame(vt[i].seq, vt[i].flip);
      rx_valid = vt[i].valid;
      tick();
      rx_valid = 1'b0;
      chk($sformatf("vec%0d_tlp_valid", i), tlp_valid, vt[i].exp_tlp);
      if (vt[i].exp_tlp) chk($sformatf("vec%0d_tlp_o", i), tlp, body_of(vt[i].seq));
      chk($sformatf("vec%0d_nrs", i), nrs, vt[i].exp_nrs);
      chk($sformatf("vec%0d_dllp_valid", i), dllp_valid, vt[i].exp_dv);
      if (vt[i].exp_dv) chk($sformatf("vec%0d_dllp_o", i), dllp, vt[i].exp_dllp);
    end

    // three frames, then an ACK from the latency timer 16 edges after the first accept
    do_reset();
    for (int s = 0; s < 3; s++) begin
      send(12'(s), -1);
      chk($sformatf("lat_tlp_valid%0d", s), tlp_valid, 1);
      chk($sformatf("lat_tlp_o%0d", s), tlp, body_of(12'(s)));
      chk($sformatf("lat_early_dllp%0d", s), dllp_valid, 0);
    end
    chk("lat_nrs", nrs, 3);
    first_at = -1; dv_count = 0; first_val = '0;
    for (int e = 3; e <= 45; e++) begin
      tick();
      if (e == 3) chk("lat_tlp_pulse_end", tlp_valid, 0);
      if (dllp_valid) begin
        dv_count++;
        if (first_at < 0) begin first_at = e; first_val = dllp; end
      end
    end
    chk("lat_ack_edge", 32'(first_at), 32'd16);
    chk("lat_ack_value", first_val, 32'h0000_0002);
    chk("lat_ack_count", 32'(dv_count), 32'd1);

    // four back-to-back frames force an immediate coalesced ACK
    do_reset();
    for (int s = 0; s < 4; s++) begin
      send(12'(s), -1);
      chk($sformatf("coal_dv%0d", s), dllp_valid, (s == 3) ? 1'b1 : 1'b0);
    end
    chk("coal_ack_value", dllp, 32'h0000_0003);
    dv_count = 0;
    for (int e = 0; e < 25; e++) begin
      tick();
      if (dllp_valid) dv_count++;
    end
    chk("coal_no_second_ack", 32'(dv_count), 32'd0);

    // sequence number wrap 4095 -> 0
    do_reset();
    for (int s = 0; s < 4095; s++) send(12'(s), -1);
    for (int e = 0; e < 40; e++) tick();
    chk("wrap_nrs_pre", nrs, 12'd4095);
    send(12'd4095, -1);
    chk("wrap_tlp_4095", tlp, body_of(12'd4095));
    chk("wrap_nrs_mid", nrs, 12'd0);
    send(12'd0, -1);
    chk("wrap_tlp_0", tlp, body_of(12'd0));
    chk("wrap_tlp_valid", tlp_valid, 1);
    chk("wrap_nrs_post", nrs, 12'd1);
    first_at = -1; first_val = '0;
    for (int e = 0; e < 40 && first_at < 0; e++) begin
      tick();
      if (dllp_valid) begin first_at = e; first_val = dllp; end
    end
    chk("wrap_ack_seen", (first_at >= 0) ? 1'b1 : 1'b0, 1'b1);
    chk("wrap_ack_value", first_val, 32'h0000_0000);

    // transaction-layer backpressure holds the second frame at the sender
    do_reset();
    tlp_ready = 1'b0;
    send(12'd0, -1);
    chk("bp_tlp_valid", tlp_valid, 1);
    chk("bp_rx_ready_low", rx_ready, 0);
    rx_data  = make_frame(12'd1, -1);
    rx_valid = 1'b1;
    tick(); tick(); tick();
    chk("bp_nrs_held", nrs, 1);
    chk("bp_rx_ready_held", rx_ready, 0);
    chk("bp_tlp_o_held", tlp, body_of(12'd0));
    tlp_ready = 1'b1;
    #1;
    chk("bp_rx_ready_comb", rx_ready, 1);
    tick();
    rx_valid = 1'b0;
    chk("bp_nrs_after", nrs, 2);
    chk("bp_tlp_o_after", tlp, body_of(12'd1));
    chk("bp_tlp_valid_after", tlp_valid, 1);

    // DLLP slot stall: NAK stays stable, a later ACK request waits behind it
    dllp_ready = 1'b0;
    send(12'd2, 50);
    chk("stall_dv", dllp_valid, 1);
    chk("stall_nak", dllp, 32'h1000_0001);
    send(12'd2, -1);
    chk("stall_nrs", nrs, 3);
    send(12'd1, -1);
    chk("stall_dup_no_tlp", tlp_valid, 0);
    for (int e = 0; e < 3; e++) begin
      tick();
      chk($sformatf("stall_hold_dv%0d", e), dllp_valid, 1);
      chk($sformatf("stall_hold_dllp%0d", e), dllp, 32'h1000_0001);
    end
    dllp_ready = 1'b1;
    tick();
    chk("stall_release_dv", dllp_valid, 1);
    chk("stall_release_ack", dllp, 32'h0000_0002);

    // reset in the middle of traffic
    send(12'd3, -1);
    chk("mid_tlp_valid", tlp_valid, 1);
    rx_data  = make_frame(12'd4, -1);
    rx_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    rx_valid = 1'b0;
    chk_idle("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
